// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU op / immediate-select enums and control bundle shared by decode and execute
package decode_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  // Base ops follow funct3 order; SUB/SRA are ADD/SRL with ctrl.alu_alt set
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  // alu_alt: SUB/SRA for arithmetic, inverted condition (BNE/BGE/BGEU) for branches
  // trap: ECALL/EBREAK, the illegal-class trap execute must raise
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       alu_alt;
    logic       trap;
  } ctrl_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction, sign-extended from instr[31]
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_sel_t    i_sel,
  output logic [31:0] o_imm
);
  logic [31:0] w_i, w_s, w_b, w_u, w_j;
  assign w_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_u = {i_instr[31:12], 12'b0};
  assign w_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  // select the format; R-type and system encodings carry no immediate
  always_comb
    o_imm = i_sel == IMM_I ? w_i :
            i_sel == IMM_S ? w_s :
            i_sel == IMM_B ? w_b :
            i_sel == IMM_U ? w_u :
            i_sel == IMM_J ? w_j : 32'b0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register read, write-back bypass and output pipeline register
// Optional STSTP_RV32M_EN enables decoding of the M-extension (MUL..REMU).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_if_valid,
  output logic                 o_if_ready,
  input  logic [31:0]          i_if_instr,
  input  logic [XLEN-1:0]      i_if_pc,
  output logic                 o_rf_read_en,
  output logic [1:0][4:0]      o_rf_read_addr,
  input  logic [1:0][XLEN-1:0] i_rf_read_data,
  input  logic                 i_wb_en,
  input  logic [4:0]           i_wb_addr,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic                 i_hazard_stall,
  input  logic                 i_flush,
  output logic                 o_id_valid,
  input  logic                 i_id_ready,
  output logic [XLEN-1:0]      o_id_pc,
  output logic [XLEN-1:0]      o_id_rs1_data,
  output logic [XLEN-1:0]      o_id_rs2_data,
  output logic [XLEN-1:0]      o_id_imm,
  output logic [4:0]           o_id_rs1,
  output logic [4:0]           o_id_rs2,
  output logic [4:0]           o_id_rd,
  output alu_op_t              o_id_alu_op,
  output ctrl_t                o_id_ctrl,
  output logic                 o_id_illegal
);
`ifdef STSTP_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  logic            r_valid, r_illegal;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  alu_op_t         r_alu_op, w_alu_op;
  ctrl_t           r_ctrl, w_ctrl;
  imm_sel_t        w_imm_sel;
  logic            w_legal, w_use_rs1, w_use_rs2, w_m, w_accept;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
  assign w_opc = i_if_instr[6:0];
  assign w_f3  = i_if_instr[14:12];
  assign w_f7  = i_if_instr[31:25];
  assign w_rd  = i_if_instr[11:7];
  assign w_m   = w_f7 == 7'b0000001;
  assign o_if_ready     = !i_hazard_stall && !i_flush && (!r_valid || i_id_ready);
  assign w_accept       = i_if_valid && o_if_ready;
  assign o_rf_read_en   = i_if_valid;
  assign o_rf_read_addr = {i_if_instr[24:20], i_if_instr[19:15]};
  // unused source fields become x0 so execute forwarding sees no false dependency
  assign w_rs1 = w_use_rs1 ? i_if_instr[19:15] : 5'd0;
  assign w_rs2 = w_use_rs2 ? i_if_instr[24:20] : 5'd0;
  assign w_rs1_data = w_rs1 == 5'd0 ? '0 : (i_wb_en && i_wb_addr == w_rs1) ? i_wb_data : i_rf_read_data[0];
  assign w_rs2_data = w_rs2 == 5'd0 ? '0 : (i_wb_en && i_wb_addr == w_rs2) ? i_wb_data : i_rf_read_data[1];
  imm_gen u_imm_gen (.i_instr(i_if_instr), .i_sel(w_imm_sel), .o_imm(w_imm));
  // opcode decode into control bundle, operand usage and legality
  always_comb begin
    w_ctrl    = '0;
    w_alu_op  = ALU_ADD;
    w_imm_sel = IMM_NONE;
    w_legal   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_imm_sel = IMM_U;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm_sel = IMM_U;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.alu_src_pc = 1'b1;
      end
      OPC_JAL: begin
        w_imm_sel = IMM_J;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.alu_src_pc = 1'b1;
      end
      OPC_JALR: begin
        w_imm_sel = IMM_I;
        w_use_rs1 = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump = 1'b1;
        w_ctrl.jalr = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_legal = w_f3 == 3'b000;
      end
      OPC_BRANCH: begin
        w_imm_sel = IMM_B;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_alt = w_f3[0];
        w_alu_op = !w_f3[2] ? ALU_XOR : w_f3[1] ? ALU_SLTU : ALU_SLT;
        w_legal = w_f3[2:1] != 2'b01;
      end
      OPC_LOAD: begin
        w_imm_sel = IMM_I;
        w_use_rs1 = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.mem_size = w_f3[1:0];
        w_ctrl.mem_unsigned = w_f3[2];
        w_ctrl.alu_src_imm = 1'b1;
        w_legal = w_f3 != 3'b011 && w_f3[2:1] != 2'b11;
      end
      OPC_STORE: begin
        w_imm_sel = IMM_S;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.mem_size = w_f3[1:0];
        w_ctrl.alu_src_imm = 1'b1;
        w_legal = !w_f3[2] && w_f3[1:0] != 2'b11;
      end
      OPC_OP_IMM: begin
        w_imm_sel = IMM_I;
        w_use_rs1 = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.alu_alt = w_f3 == 3'b101 && w_f7[5];
        w_alu_op = alu_op_t'({1'b0, w_f3});
        w_legal = w_f3 == 3'b001 ? w_f7 == 7'd0 : w_f3 == 3'b101 ? (w_f7 & 7'b1011111) == 7'd0 : 1'b1;
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_alt = w_f7[5];
        w_alu_op = alu_op_t'({w_m, w_f3});
        w_legal = w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) || (M_EN && w_m);
      end
      OPC_FENCE: w_legal = w_f3 == 3'b000;
      OPC_SYSTEM: begin
        w_ctrl.trap = 1'b1;
        w_legal = i_if_instr == 32'h0000_0073 || i_if_instr == 32'h0010_0073;
      end
      default: w_legal = 1'b0;
    endcase
    w_ctrl.reg_write = w_ctrl.reg_write && w_rd != 5'd0;
    w_ctrl   = w_legal ? w_ctrl : '0;
    w_alu_op = w_legal ? w_alu_op : ALU_ADD;
  end
  // output pipeline register: flush kills, accept loads, a taken bundle drains, otherwise hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_alu_op   <= ALU_ADD;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
    end else if (i_flush) r_valid <= 1'b0;
    else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= i_if_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_alu_op   <= w_alu_op;
      r_ctrl     <= w_ctrl;
      r_illegal  <= !w_legal;
    end else if (i_id_ready) r_valid <= 1'b0;
  assign o_id_valid    = r_valid;
  assign o_id_pc       = r_pc;
  assign o_id_rs1_data = r_rs1_data;
  assign o_id_rs2_data = r_rs2_data;
  assign o_id_imm      = r_imm;
  assign o_id_rs1      = r_rs1;
  assign o_id_rs2      = r_rs2;
  assign o_id_rd       = r_rd;
  assign o_id_alu_op   = r_alu_op;
  assign o_id_ctrl     = r_ctrl;
  assign o_id_illegal  = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector self-checking bench for decode_stage (honours STSTP_RV32M_EN)
module tb_decode_stage;
  import decode_pkg::*;
  logic             clk = 1'b0, rst_n = 1'b0;
  logic             if_valid = 1'b0, if_ready, rf_read_en;
  logic [31:0]      if_instr = '0, if_pc = '0;
  logic [1:0][4:0]  rf_read_addr;
  logic [1:0][31:0] rf_read_data;
  logic             wb_en = 1'b0, hazard_stall = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic [4:0]       wb_addr = '0;
  logic [31:0]      wb_data = '0;
  logic             id_valid, id_illegal;
  logic [31:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  alu_op_t          id_alu_op;
  ctrl_t            id_ctrl;
  logic [31:0]      rf [32];
  int               n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  // register file model: x0 deliberately holds garbage so the x0-is-zero rule is exercised
  assign rf_read_data[0] = rf[rf_read_addr[0]];
  assign rf_read_data[1] = rf[rf_read_addr[1]];
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(if_ready),
    .i_if_instr(if_instr), .i_if_pc(if_pc), .o_rf_read_en(rf_read_en),
    .o_rf_read_addr(rf_read_addr), .i_rf_read_data(rf_read_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_hazard_stall(hazard_stall), .i_flush(flush), .o_id_valid(id_valid),
    .i_id_ready(id_ready), .o_id_pc(id_pc), .o_id_rs1_data(id_rs1_data),
    .o_id_rs2_data(id_rs2_data), .o_id_imm(id_imm), .o_id_rs1(id_rs1),
    .o_id_rs2(id_rs2), .o_id_rd(id_rd), .o_id_alu_op(id_alu_op),
    .o_id_ctrl(id_ctrl), .o_id_illegal(id_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    @(posedge clk);
    #1 if_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd7;
    rf[2] = 32'd100;
    #12;
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_imm", id_imm, 0);
    chk("rst_ctrl", id_ctrl, 0);
    chk("rst_alu", id_alu_op, 0);
    chk("rst_if_ready", if_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    id_ready = 1'b1;
    // addi x5,x0,-1 with a write-back to x0 that must not bypass
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h100;
    #1;
    chk("rf_read_en", rf_read_en, 1);
    chk("rf_addr_rs1", rf_read_addr[0], 0);
    chk("rf_addr_rs2", rf_read_addr[1], 31);
    issue(32'hFFF00293, 32'h100);
    chk("addi_valid", id_valid, 1);
    chk("addi_imm", id_imm, 32'hFFFF_FFFF);
    chk("addi_rd", id_rd, 5);
    chk("addi_src_imm", id_ctrl.alu_src_imm, 1);
    chk("addi_reg_write", id_ctrl.reg_write, 1);
    chk("addi_rs1_data", id_rs1_data, 0);
    chk("addi_pc", id_pc, 32'h100);
    // add x3,x1,x2 with x2 written back this cycle
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
    issue(32'h002081B3, 32'h104);
    chk("add_rs1_data", id_rs1_data, 7);
    chk("add_rs2_data", id_rs2_data, 9);
    chk("add_rd", id_rd, 3);
    chk("add_alu", id_alu_op, ALU_ADD);
    chk("add_alt", id_ctrl.alu_alt, 0);
    wb_en = 1'b0;
    issue(32'h402081B3, 32'h108);
    chk("sub_alt", id_ctrl.alu_alt, 1);
    chk("sub_rs2_data", id_rs2_data, 100);
    issue(32'h00000013, 32'h10C);
    chk("nop_reg_write", id_ctrl.reg_write, 0);
    chk("nop_illegal", id_illegal, 0);
    // lw x6,8(x1) then execute stalls three cycles while sw waits
    issue(32'h0080A303, 32'h110);
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'hFE20AE23; if_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_if_ready", if_ready, 0);
      chk("stall_pc", id_pc, 32'h110);
      chk("stall_imm", id_imm, 8);
      chk("stall_mem_read", id_ctrl.mem_read, 1);
    end
    chk("lw_mem_size", id_ctrl.mem_size, 2);
    id_ready = 1'b1;
    #1 chk("unstall_if_ready", if_ready, 1);
    @(posedge clk);
    #1 if_valid = 1'b0;
    chk("sw_pc", id_pc, 32'h200);
    chk("sw_imm", id_imm, 32'hFFFF_FFFC);
    chk("sw_mem_write", id_ctrl.mem_write, 1);
    chk("sw_reg_write", id_ctrl.reg_write, 0);
    issue(32'hFE208CE3, 32'h204);
    chk("beq_imm", id_imm, 32'hFFFF_FFF8);
    chk("beq_branch", id_ctrl.branch, 1);
    issue(32'h123453B7, 32'h208);
    chk("lui_imm", id_imm, 32'h1234_5000);
    chk("lui_rs1", id_rs1, 0);
    issue(32'h010000EF, 32'h20C);
    chk("jal_imm", id_imm, 16);
    chk("jal_jump", id_ctrl.jump, 1);
    chk("jal_src_pc", id_ctrl.alu_src_pc, 1);
    issue(32'h02208033, 32'h210);
    chk("mul_valid", id_valid, 1);
`ifdef STSTP_RV32M_EN
    chk("mul_alu", id_alu_op, ALU_MUL);
    chk("mul_reg_write", id_ctrl.reg_write, 0);
    chk("mul_illegal", id_illegal, 0);
`else
    chk("mul_illegal", id_illegal, 1);
    chk("mul_ctrl", id_ctrl, 0);
`endif
    issue(32'hFFFF_FFFF, 32'h214);
    chk("bad_valid", id_valid, 1);
    chk("bad_illegal", id_illegal, 1);
    chk("bad_ctrl", id_ctrl, 0);
    issue(32'h0000_0073, 32'h218);
    chk("ecall_trap", id_ctrl.trap, 1);
    chk("ecall_illegal", id_illegal, 0);
    @(posedge clk);
    #1 chk("drain_valid", id_valid, 0);
    // flush with a held bundle and a waiting instruction
    issue(32'h002081B3, 32'h300);
    id_ready = 1'b0;
    flush = 1'b1;
    if_valid = 1'b1;
    #1 chk("flush_if_ready", if_ready, 0);
    @(posedge clk);
    #1 chk("flush_valid", id_valid, 0);
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    // asynchronous reset while stalled
    issue(32'h0080A303, 32'h400);
    id_ready = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_valid", id_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", id_valid, 0);
    chk("async_rst_pc", id_pc, 0);
    chk("async_rst_imm", id_imm, 0);
    chk("async_rst_ctrl", id_ctrl, 0);
    @(negedge clk) rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
